axi_lite_arbiter: RTL and testbench
===================================

# axi_lite_arbiter

Two-requester AXI-Lite arbiter that shares the single AXI-Lite port of the UART Lite peripheral between the command master (requester 0) and a second bus user such as a status poller or LED/DIP bridge (requester 1). It grants one complete transaction at a time, either a write (AW+W+B) or a read (AR+R). It routes address, data and response channels between the granted requester and the slave, and holds the grant until that transaction's response handshake completes. It sits between the masters and the UART Lite slave interface, on the 100 MHz AXI clock.

## Interface
Parameters:
- ADDR_W, 4, AXI-Lite address width (UART Lite register offsets 0x0–0xC)
- DATA_W, 32, AXI-Lite data width

Ports (n ∈ {0,1}; each requester group is one port per signal):
- i_axi_aclk_100MHZ  input  1  clock
- i_axi_rst_n  input  1  asynchronous, active-low reset
- i_m\<n\>_awaddr/awvalid, o_m\<n\>_awready  in/in/out  ADDR_W/1/1  requester n write address
- i_m\<n\>_wdata/wstrb/wvalid, o_m\<n\>_wready  in/in/in/out  DATA_W/4/1/1  requester n write data
- o_m\<n\>_bresp/bvalid, i_m\<n\>_bready  out/out/in  2/1/1  requester n write response
- i_m\<n\>_araddr/arvalid, o_m\<n\>_arready  in/in/out  ADDR_W/1/1  requester n read address
- o_m\<n\>_rdata/rresp/rvalid, i_m\<n\>_rready  out/out/out/in  DATA_W/2/1/1  requester n read data
- o_axi_awaddr/awvalid, i_axi_awready; o_axi_wdata/wstrb/wvalid, i_axi_wready; i_axi_bresp/bvalid, o_axi_bready  slave write channels
- o_axi_araddr/arvalid, i_axi_arready; i_axi_rdata/rresp/rvalid, o_axi_rready  slave read channels
- o_grant  output  2  one-hot current grant (00 = idle)
- o_busy  output  1  transaction in progress

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- A requester n is requesting a write when i_m\<n\>_awvalid or i_m\<n\>_wvalid is high. It is requesting a read when i_m\<n\>_arvalid is high.
- IDLE: pick a requester. If both are requesting, the round-robin pointer decides (the last-completed requester loses). Within the chosen requester, a write wins over a read. Register the grant and go to WR_ADDR_DATA or RD_ADDR.
- WR_ADDR_DATA: forward AW and W of the granted requester independently. Track aw_done and w_done flags; each is set on its own valid&&ready. Go to WR_RESP when both flags are set, including when both are set in the same cycle.
- WR_RESP: o_axi_bready = i_m\<g\>_bready. Route bresp/bvalid to the granted requester. On a B handshake: clear the flags, set the pointer to the other requester, return to IDLE.
- RD_ADDR: forward AR. On an AR handshake go to RD_DATA.
- RD_DATA: route rdata/rresp/rvalid to the granted requester. On an R handshake: update the pointer, return to IDLE.
- Non-granted requester: all its ready and valid outputs are 0; its data and resp outputs are 0.
- Slave-side outputs are muxed combinationally from the registered grant and state. The valids are gated off once the matching done flag is set, so there is no duplicate AW or W.
- bresp and rresp pass through unmodified. SLVERR (2'b10) reaches the requester as-is.

## Timing
- Reset, asynchronous: state IDLE, grant 00, pointer to requester 0, flags cleared. Every output reads 0, including o_axi_bready and o_axi_rready.
- Arbitration latency: 1 cycle. A request visible in IDLE at edge k produces slave-side valid in cycle k+1.
- Turnaround: 1 idle cycle between back-to-back transactions, spent in IDLE.
- Minimum write transaction: 3 cycles (IDLE, WR_ADDR_DATA, WR_RESP) with a zero-wait slave. Minimum read transaction: 3 cycles.
- A request arriving on the non-granted requester mid-transaction waits. Its valids are held by AXI rules and are never dropped.
- Reset asserted mid-transaction: immediate return to IDLE. Any slave response still outstanding is not the arbiter's responsibility.
- Requesters must hold valid and payload stable until ready, per AXI-Lite.

## Configuration
- ARB_RR_EN defined: round-robin pointer as described above.
- ARB_RR_EN undefined: fixed priority. Requester 0 always wins simultaneous requests and the pointer logic is removed. The write-over-read rule within a requester is unchanged.

## Structure
- Shared package axi_lite_pkg: state encoding constants (IDLE=0 … RD_DATA=4), the response codes OKAY=2'b00 and SLVERR=2'b10, and the UART Lite register offsets RX=0x0, TX=0x4, STAT=0x8, CTRL=0xC.
- One natural sub-module, axi_lite_rr_pick: 2-way request/pointer-to-grant logic. It is replaced by fixed priority under !ARB_RR_EN.

## Test plan
- m0 writes 0x50 to 0x4 while m1 is idle. Expect: o_axi_awaddr=0x4, o_axi_wdata=0x50, then o_m0_bvalid with bresp 00, o_grant 01→00, and m1 sees no handshakes.
- m0 and m1 both assert arvalid (0x8 and 0x0) in the same cycle, from reset. Expect: m0 served first, m1 second with one idle cycle between. With ARB_RR_EN, a repeat of the same pair serves m1 first.
- Slave asserts awready 2 cycles before wready. Expect: exactly one AW handshake, o_axi_awvalid drops after it, and B arrives only after the W handshake.
- m1 holds both a write (0xC←0x10) and a read (0x8) pending. Expect: the write completes before the read starts.
- Slave returns rresp=2'b10 with rdata 0x35 to m1. Expect: o_m1_rresp=10, o_m1_rdata=0x35, and m0's outputs all 0.
- Reset pulsed in WR_RESP with bvalid low. Expect: all outputs 0 within the reset cycle, and a fresh m0 write after release completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite arbiter in front of the UART Lite port:
// FSM state encoding, AXI response codes and UART Lite register offsets.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] REG_RX   = 4'h0;
  localparam logic [3:0] REG_TX   = 4'h4;
  localparam logic [3:0] REG_STAT = 4'h8;
  localparam logic [3:0] REG_CTRL = 4'hC;

  function automatic logic [1:0] onehot_of(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// One AXI-Lite port (AW/W/B/AR/R) with master and slave views, used to bundle
// the requester and slave sides of axi_lite_arbiter.
interface axi_lite_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  // Every channel transfers on the cycle where valid && ready; the source
  // holds valid and payload stable until that cycle and never retracts valid.
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_rr_pick.sv
// 2-way request-to-grant picker. With ARB_RR_EN defined the pointer names the
// requester that wins a tie; otherwise requester 0 always wins a tie.
module axi_lite_rr_pick
  import axi_lite_pkg::*;
(
  input  logic [1:0] i_req,
`ifdef ARB_RR_EN
  input  logic       i_ptr,
`endif
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
`ifdef ARB_RR_EN
      o_grant = onehot_of(i_ptr);
`else
      o_grant = onehot_of(1'b0);
`endif
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-requester AXI-Lite arbiter for the UART Lite port: one whole write or read
// at a time, grant held until its response handshake. ARB_RR_EN selects round-robin.
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              i_axi_aclk_100MHZ,
  input  logic              i_axi_rst_n,
  input  logic [ADDR_W-1:0] i_m0_awaddr,
  input  logic              i_m0_awvalid,
  output logic              o_m0_awready,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic [3:0]        i_m0_wstrb,
  input  logic              i_m0_wvalid,
  output logic              o_m0_wready,
  output logic [1:0]        o_m0_bresp,
  output logic              o_m0_bvalid,
  input  logic              i_m0_bready,
  input  logic [ADDR_W-1:0] i_m0_araddr,
  input  logic              i_m0_arvalid,
  output logic              o_m0_arready,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic [1:0]        o_m0_rresp,
  output logic              o_m0_rvalid,
  input  logic              i_m0_rready,
  input  logic [ADDR_W-1:0] i_m1_awaddr,
  input  logic              i_m1_awvalid,
  output logic              o_m1_awready,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic [3:0]        i_m1_wstrb,
  input  logic              i_m1_wvalid,
  output logic              o_m1_wready,
  output logic [1:0]        o_m1_bresp,
  output logic              o_m1_bvalid,
  input  logic              i_m1_bready,
  input  logic [ADDR_W-1:0] i_m1_araddr,
  input  logic              i_m1_arvalid,
  output logic              o_m1_arready,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [1:0]        o_m1_rresp,
  output logic              o_m1_rvalid,
  input  logic              i_m1_rready,
  output logic [ADDR_W-1:0] o_axi_awaddr,
  output logic              o_axi_awvalid,
  input  logic              i_axi_awready,
  output logic [DATA_W-1:0] o_axi_wdata,
  output logic [3:0]        o_axi_wstrb,
  output logic              o_axi_wvalid,
  input  logic              i_axi_wready,
  input  logic [1:0]        i_axi_bresp,
  input  logic              i_axi_bvalid,
  output logic              o_axi_bready,
  output logic [ADDR_W-1:0] o_axi_araddr,
  output logic              o_axi_arvalid,
  input  logic              i_axi_arready,
  input  logic [DATA_W-1:0] i_axi_rdata,
  input  logic [1:0]        i_axi_rresp,
  input  logic              i_axi_rvalid,
  output logic              o_axi_rready,
  output logic [1:0]        o_grant,
  output logic              o_busy,
  output logic [2:0]        o_dbg_state
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [1:0] req, pick;
  logic       req0_wr, req1_wr, gsel;
  logic       in_wad, in_wrr, in_rda, in_rdd;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;

`ifdef ARB_RR_EN
  logic       ptr_q, ptr_d;
`endif

  assign req0_wr = i_m0_awvalid | i_m0_wvalid;
  assign req1_wr = i_m1_awvalid | i_m1_wvalid;
  assign req     = {req1_wr | i_m1_arvalid, req0_wr | i_m0_arvalid};
  assign gsel    = grant_q[1];

  axi_lite_rr_pick u_pick (
    .i_req   (req),
`ifdef ARB_RR_EN
    .i_ptr   (ptr_q),
`endif
    .o_grant (pick)
  );

  always_ff @(posedge i_axi_aclk_100MHZ or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge i_axi_aclk_100MHZ or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) ptr_q <= 1'b0;
    else              ptr_q <= ptr_d;
  end
`endif

  assign aw_hs = o_axi_awvalid & i_axi_awready;
  assign w_hs  = o_axi_wvalid  & i_axi_wready;
  assign b_hs  = i_axi_bvalid  & o_axi_bready;
  assign ar_hs = o_axi_arvalid & i_axi_arready;
  assign r_hs  = i_axi_rvalid  & o_axi_rready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick != 2'b00) begin
          grant_d = pick;
          // Within the chosen requester a pending write beats a pending read.
          state_d = (pick[1] ? req1_wr : req0_wr) ? ST_WR_ADDR_DATA : ST_RD_ADDR;
        end
      end
      ST_WR_ADDR_DATA: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q  | w_hs;
        if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (b_hs) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          grant_d   = 2'b00;
          state_d   = ST_IDLE;
`ifdef ARB_RR_EN
          ptr_d     = ~gsel;
`endif
        end
      end
      ST_RD_ADDR: begin
        if (ar_hs) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (r_hs) begin
          grant_d = 2'b00;
          state_d = ST_IDLE;
`ifdef ARB_RR_EN
          ptr_d   = ~gsel;
`endif
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_wad = (state_q == ST_WR_ADDR_DATA);
  assign in_wrr = (state_q == ST_WR_RESP);
  assign in_rda = (state_q == ST_RD_ADDR);
  assign in_rdd = (state_q == ST_RD_DATA);

  always_comb begin
    // Slave side: muxed from the registered grant; done flags stop repeat AW/W.
    o_axi_awaddr  = in_wad ? (gsel ? i_m1_awaddr : i_m0_awaddr) : '0;
    o_axi_awvalid = in_wad && !aw_done_q && (gsel ? i_m1_awvalid : i_m0_awvalid);
    o_axi_wdata   = in_wad ? (gsel ? i_m1_wdata : i_m0_wdata) : '0;
    o_axi_wstrb   = in_wad ? (gsel ? i_m1_wstrb : i_m0_wstrb) : '0;
    o_axi_wvalid  = in_wad && !w_done_q && (gsel ? i_m1_wvalid : i_m0_wvalid);
    o_axi_bready  = in_wrr && (gsel ? i_m1_bready : i_m0_bready);
    o_axi_araddr  = in_rda ? (gsel ? i_m1_araddr : i_m0_araddr) : '0;
    o_axi_arvalid = in_rda && (gsel ? i_m1_arvalid : i_m0_arvalid);
    o_axi_rready  = in_rdd && (gsel ? i_m1_rready : i_m0_rready);

    o_m0_awready = grant_q[0] && in_wad && !aw_done_q && i_axi_awready;
    o_m0_wready  = grant_q[0] && in_wad && !w_done_q && i_axi_wready;
    o_m0_bvalid  = grant_q[0] && in_wrr && i_axi_bvalid;
    o_m0_bresp   = (grant_q[0] && in_wrr) ? i_axi_bresp : 2'b00;
    o_m0_arready = grant_q[0] && in_rda && i_axi_arready;
    o_m0_rvalid  = grant_q[0] && in_rdd && i_axi_rvalid;
    o_m0_rdata   = (grant_q[0] && in_rdd) ? i_axi_rdata : '0;
    o_m0_rresp   = (grant_q[0] && in_rdd) ? i_axi_rresp : 2'b00;

    o_m1_awready = grant_q[1] && in_wad && !aw_done_q && i_axi_awready;
    o_m1_wready  = grant_q[1] && in_wad && !w_done_q && i_axi_wready;
    o_m1_bvalid  = grant_q[1] && in_wrr && i_axi_bvalid;
    o_m1_bresp   = (grant_q[1] && in_wrr) ? i_axi_bresp : 2'b00;
    o_m1_arready = grant_q[1] && in_rda && i_axi_arready;
    o_m1_rvalid  = grant_q[1] && in_rdd && i_axi_rvalid;
    o_m1_rdata   = (grant_q[1] && in_rdd) ? i_axi_rdata : '0;
    o_m1_rresp   = (grant_q[1] && in_rdd) ? i_axi_rresp : 2'b00;

    o_grant     = grant_q;
    o_busy      = (state_q != ST_IDLE);
    o_dbg_state = state_q;
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter; honours ARB_RR_EN when it is defined.
module tb_axi_lite_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant;
  logic       busy;
  logic [2:0] dbg_state;
  int         checks = 0;
  int         failures = 0;
  int         aw_hs_cnt = 0;
  int         w_hs_cnt = 0;

  axi_lite_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  axi_lite_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
  axi_lite_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

  // clock / reset
  always #5 clk = ~clk;

  axi_lite_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_axi_aclk_100MHZ (clk),
    .i_axi_rst_n   (rst_n),
    .i_m0_awaddr   (m0_if.awaddr),  .i_m0_awvalid (m0_if.awvalid), .o_m0_awready (m0_if.awready),
    .i_m0_wdata    (m0_if.wdata),   .i_m0_wstrb   (m0_if.wstrb),   .i_m0_wvalid  (m0_if.wvalid),
    .o_m0_wready   (m0_if.wready),  .o_m0_bresp   (m0_if.bresp),   .o_m0_bvalid  (m0_if.bvalid),
    .i_m0_bready   (m0_if.bready),  .i_m0_araddr  (m0_if.araddr),  .i_m0_arvalid (m0_if.arvalid),
    .o_m0_arready  (m0_if.arready), .o_m0_rdata   (m0_if.rdata),   .o_m0_rresp   (m0_if.rresp),
    .o_m0_rvalid   (m0_if.rvalid),  .i_m0_rready  (m0_if.rready),
    .i_m1_awaddr   (m1_if.awaddr),  .i_m1_awvalid (m1_if.awvalid), .o_m1_awready (m1_if.awready),
    .i_m1_wdata    (m1_if.wdata),   .i_m1_wstrb   (m1_if.wstrb),   .i_m1_wvalid  (m1_if.wvalid),
    .o_m1_wready   (m1_if.wready),  .o_m1_bresp   (m1_if.bresp),   .o_m1_bvalid  (m1_if.bvalid),
    .i_m1_bready   (m1_if.bready),  .i_m1_araddr  (m1_if.araddr),  .i_m1_arvalid (m1_if.arvalid),
    .o_m1_arready  (m1_if.arready), .o_m1_rdata   (m1_if.rdata),   .o_m1_rresp   (m1_if.rresp),
    .o_m1_rvalid   (m1_if.rvalid),  .i_m1_rready  (m1_if.rready),
    .o_axi_awaddr  (s_if.awaddr),   .o_axi_awvalid (s_if.awvalid), .i_axi_awready (s_if.awready),
    .o_axi_wdata   (s_if.wdata),    .o_axi_wstrb   (s_if.wstrb),   .o_axi_wvalid  (s_if.wvalid),
    .i_axi_wready  (s_if.wready),   .i_axi_bresp   (s_if.bresp),   .i_axi_bvalid  (s_if.bvalid),
    .o_axi_bready  (s_if.bready),   .o_axi_araddr  (s_if.araddr),  .o_axi_arvalid (s_if.arvalid),
    .i_axi_arready (s_if.arready),  .i_axi_rdata   (s_if.rdata),   .i_axi_rresp   (s_if.rresp),
    .i_axi_rvalid  (s_if.rvalid),   .o_axi_rready  (s_if.rready),
    .o_grant       (grant),
    .o_busy        (busy),
    .o_dbg_state   (dbg_state)
  );

  logic [40:0]  m0_out, m1_out;
  logic [48:0]  s_out;
  logic [136:0] all_out;
  assign m0_out  = {m0_if.awready, m0_if.wready, m0_if.bresp, m0_if.bvalid, m0_if.arready,
                    m0_if.rdata, m0_if.rresp, m0_if.rvalid};
  assign m1_out  = {m1_if.awready, m1_if.wready, m1_if.bresp, m1_if.bvalid, m1_if.arready,
                    m1_if.rdata, m1_if.rresp, m1_if.rvalid};
  assign s_out   = {s_if.awaddr, s_if.awvalid, s_if.wdata, s_if.wstrb, s_if.wvalid, s_if.bready,
                    s_if.araddr, s_if.arvalid, s_if.rready};
  assign all_out = {m0_out, m1_out, s_out, grant, busy, dbg_state};

  // Slave-side handshakes that will complete at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && s_if.awvalid && s_if.awready) aw_hs_cnt <= aw_hs_cnt + 1;
    if (rst_n && s_if.wvalid && s_if.wready) w_hs_cnt <= w_hs_cnt + 1;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.awaddr = '0; m0_if.awvalid = 0; m0_if.wdata = '0; m0_if.wstrb = '0; m0_if.wvalid = 0;
    m0_if.bready = 0;  m0_if.araddr = '0; m0_if.arvalid = 0; m0_if.rready = 0;
    m1_if.awaddr = '0; m1_if.awvalid = 0; m1_if.wdata = '0; m1_if.wstrb = '0; m1_if.wvalid = 0;
    m1_if.bready = 0;  m1_if.araddr = '0; m1_if.arvalid = 0; m1_if.rready = 0;
    s_if.awready = 0;  s_if.wready = 0;   s_if.bresp = '0;  s_if.bvalid = 0;
    s_if.arready = 0;  s_if.rdata = '0;   s_if.rresp = '0;  s_if.rvalid = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    m0_if.awvalid = 1; m0_if.wvalid = 1; m0_if.arvalid = 1; m0_if.bready = 1; m0_if.rready = 1;
    m1_if.arvalid = 1; m1_if.bready = 1; m1_if.rready = 1;
    s_if.awready = 1; s_if.wready = 1; s_if.arready = 1; s_if.bvalid = 1; s_if.rvalid = 1;
    s_if.rdata = 32'hdead_beef; s_if.rresp = 2'b10; s_if.bresp = 2'b10;
    step();
    step();
    checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_all_out: got %h exp 0", all_out); end
    clear_inputs();
    rst_n = 1'b1;
    step();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b exp 00", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b exp 0", busy); end
  endtask

  task automatic test_single_write();
    m0_if.awaddr = 4'h4; m0_if.awvalid = 1; m0_if.wdata = 32'h50; m0_if.wstrb = 4'hf;
    m0_if.wvalid = 1; m0_if.bready = 1;
    s_if.awready = 1; s_if.wready = 1;
    #1;
    checks++; if (s_if.awvalid !== 1'b0) begin failures++; $display("FAIL wr_latency_awvalid: got %b exp 0", s_if.awvalid); end
    step();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL wr_grant: got %b exp 01", grant); end
    checks++; if (s_if.awaddr !== 4'h4) begin failures++; $display("FAIL wr_awaddr: got %h exp 4", s_if.awaddr); end
    checks++; if (s_if.wdata !== 32'h50) begin failures++; $display("FAIL wr_wdata: got %h exp 50", s_if.wdata); end
    checks++; if ({s_if.awvalid, s_if.wvalid, m0_if.awready, m0_if.wready} !== 4'b1111) begin
      failures++; $display("FAIL wr_aw_w_hs: got %b exp 1111", {s_if.awvalid, s_if.wvalid, m0_if.awready, m0_if.wready}); end
    checks++; if (m1_out !== '0) begin failures++; $display("FAIL wr_m1_quiet_a: got %h exp 0", m1_out); end
    step();
    m0_if.awvalid = 0; m0_if.wvalid = 0;
    s_if.bvalid = 1; s_if.bresp = 2'b00;
    #1;
    checks++; if ({m0_if.bvalid, m0_if.bresp, s_if.bready} !== 4'b1001) begin
      failures++; $display("FAIL wr_bresp: got %b exp 1001", {m0_if.bvalid, m0_if.bresp, s_if.bready}); end
    checks++; if (m1_out !== '0) begin failures++; $display("FAIL wr_m1_quiet_b: got %h exp 0", m1_out); end
    step();
    s_if.bvalid = 0; m0_if.bready = 0;
    #1;
    checks++; if ({grant, busy} !== 3'b000) begin failures++; $display("FAIL wr_done_idle: got %b exp 000", {grant, busy}); end
    clear_inputs();
  endtask

  task automatic test_simul_reads();
    logic [1:0] win_g, oth_g;
    logic [3:0] win_a, oth_a;
    win_g = RR ? 2'b10 : 2'b01;
    oth_g = RR ? 2'b01 : 2'b10;
    win_a = RR ? 4'h0 : 4'h8;
    oth_a = RR ? 4'h8 : 4'h0;
    do_reset();
    m0_if.araddr = 4'h8; m0_if.arvalid = 1; m0_if.rready = 1;
    m1_if.araddr = 4'h0; m1_if.arvalid = 1; m1_if.rready = 1;
    s_if.arready = 1;
    #1;
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rd_pre_grant: got %b exp 00", grant); end
    step();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rd_first_grant: got %b exp 01", grant); end
    checks++; if ({s_if.araddr, s_if.arvalid, m1_if.arready} !== 6'b1000_1_0) begin
      failures++; $display("FAIL rd_first_ar: got %b exp 100010", {s_if.araddr, s_if.arvalid, m1_if.arready}); end
    step();
    m0_if.arvalid = 0; s_if.rvalid = 1; s_if.rdata = 32'h11;
    #1;
    checks++; if ({m0_if.rvalid, m0_if.rdata} !== {1'b1, 32'h11}) begin
      failures++; $display("FAIL rd_first_r: got %b/%h exp 1/11", m0_if.rvalid, m0_if.rdata); end
    checks++; if (m1_out !== '0) begin failures++; $display("FAIL rd_m1_waits: got %h exp 0", m1_out); end
    step();
    s_if.rvalid = 0; m0_if.arvalid = 1;
    #1;
    checks++; if ({grant, busy} !== 3'b000) begin failures++; $display("FAIL rd_turnaround: got %b exp 000", {grant, busy}); end
    step();
    checks++; if (grant !== win_g) begin failures++; $display("FAIL rd_repeat_grant: got %b exp %b", grant, win_g); end
    checks++; if (s_if.araddr !== win_a) begin failures++; $display("FAIL rd_repeat_addr: got %h exp %h", s_if.araddr, win_a); end
    step();
    if (RR) m1_if.arvalid = 0; else m0_if.arvalid = 0;
    s_if.rvalid = 1; s_if.rdata = 32'h22;
    #1;
    checks++; if ((RR ? m1_if.rdata : m0_if.rdata) !== 32'h22) begin
      failures++; $display("FAIL rd_repeat_rdata: got %h exp 22", RR ? m1_if.rdata : m0_if.rdata); end
    step();
    s_if.rvalid = 0;
    step();
    checks++; if (grant !== oth_g) begin failures++; $display("FAIL rd_other_grant: got %b exp %b", grant, oth_g); end
    checks++; if (s_if.araddr !== oth_a) begin failures++; $display("FAIL rd_other_addr: got %h exp %h", s_if.araddr, oth_a); end
    step();
    m0_if.arvalid = 0; m1_if.arvalid = 0; s_if.rvalid = 1; s_if.rdata = 32'h33;
    #1;
    checks++; if ((RR ? m0_if.rdata : m1_if.rdata) !== 32'h33) begin
      failures++; $display("FAIL rd_other_rdata: got %h exp 33", RR ? m0_if.rdata : m1_if.rdata); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_aw_before_w();
    int aw0, w0;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    m0_if.awaddr = 4'h4; m0_if.awvalid = 1; m0_if.wdata = 32'ha5; m0_if.wstrb = 4'hf;
    m0_if.wvalid = 1; m0_if.bready = 1;
    s_if.awready = 1; s_if.wready = 0;
    step();
    #1;
    checks++; if ({s_if.awvalid, s_if.wvalid, m0_if.wready} !== 3'b110) begin
      failures++; $display("FAIL aww_first: got %b exp 110", {s_if.awvalid, s_if.wvalid, m0_if.wready}); end
    step();
    checks++; if ({s_if.awvalid, m0_if.awready, s_if.wvalid} !== 3'b001) begin
      failures++; $display("FAIL aww_aw_gated: got %b exp 001", {s_if.awvalid, m0_if.awready, s_if.wvalid}); end
    checks++; if ({dbg_state, m0_if.bvalid, s_if.bready} !== 5'b001_0_0) begin
      failures++; $display("FAIL aww_no_b_yet: got %b exp 00100", {dbg_state, m0_if.bvalid, s_if.bready}); end
    step();
    s_if.wready = 1;
    #1;
    checks++; if ({s_if.awvalid, m0_if.wready} !== 2'b01) begin
      failures++; $display("FAIL aww_w_hs: got %b exp 01", {s_if.awvalid, m0_if.wready}); end
    step();
    m0_if.awvalid = 0; m0_if.wvalid = 0; s_if.bvalid = 1;
    #1;
    checks++; if ({dbg_state, m0_if.bvalid} !== 4'b010_1) begin
      failures++; $display("FAIL aww_b: got %b exp 0101", {dbg_state, m0_if.bvalid}); end
    step();
    s_if.bvalid = 0;
    step();
    checks++; if (aw_hs_cnt - aw0 !== 1) begin failures++; $display("FAIL aww_aw_count: got %0d exp 1", aw_hs_cnt - aw0); end
    checks++; if (w_hs_cnt - w0 !== 1) begin failures++; $display("FAIL aww_w_count: got %0d exp 1", w_hs_cnt - w0); end
    clear_inputs();
  endtask

  task automatic test_write_over_read();
    m1_if.awaddr = 4'hC; m1_if.awvalid = 1; m1_if.wdata = 32'h10; m1_if.wstrb = 4'hf;
    m1_if.wvalid = 1; m1_if.bready = 1;
    m1_if.araddr = 4'h8; m1_if.arvalid = 1; m1_if.rready = 1;
    s_if.awready = 1; s_if.wready = 1; s_if.arready = 1;
    step();
    checks++; if ({grant, dbg_state} !== 5'b10_001) begin failures++; $display("FAIL wor_write_first: got %b exp 10001", {grant, dbg_state}); end
    checks++; if ({s_if.awaddr, s_if.wdata} !== {4'hC, 32'h10}) begin
      failures++; $display("FAIL wor_payload: got %h/%h exp c/10", s_if.awaddr, s_if.wdata); end
    checks++; if ({s_if.arvalid, m1_if.arready} !== 2'b00) begin
      failures++; $display("FAIL wor_ar_held: got %b exp 00", {s_if.arvalid, m1_if.arready}); end
    step();
    m1_if.awvalid = 0; m1_if.wvalid = 0; s_if.bvalid = 1;
    #1;
    checks++; if ({m1_if.bvalid, s_if.arvalid} !== 2'b10) begin
      failures++; $display("FAIL wor_b: got %b exp 10", {m1_if.bvalid, s_if.arvalid}); end
    step();
    s_if.bvalid = 0;
    step();
    checks++; if ({grant, dbg_state, s_if.araddr, s_if.arvalid} !== {2'b10, 3'd3, 4'h8, 1'b1}) begin
      failures++; $display("FAIL wor_read_next: got %b exp 10011_1000_1", {grant, dbg_state, s_if.araddr, s_if.arvalid}); end
    step();
    m1_if.arvalid = 0; s_if.rvalid = 1; s_if.rdata = 32'h77;
    #1;
    checks++; if ({m1_if.rvalid, m1_if.rdata} !== {1'b1, 32'h77}) begin
      failures++; $display("FAIL wor_r: got %b/%h exp 1/77", m1_if.rvalid, m1_if.rdata); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_slverr_read();
    m1_if.araddr = 4'h8; m1_if.arvalid = 1; m1_if.rready = 1;
    s_if.arready = 1;
    step();
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL err_grant: got %b exp 10", grant); end
    step();
    m1_if.arvalid = 0; s_if.rvalid = 1; s_if.rdata = 32'h35; s_if.rresp = 2'b10;
    #1;
    checks++; if ({m1_if.rresp, m1_if.rdata, m1_if.rvalid} !== {2'b10, 32'h35, 1'b1}) begin
      failures++; $display("FAIL err_rresp: got %b/%h/%b exp 10/35/1", m1_if.rresp, m1_if.rdata, m1_if.rvalid); end
    checks++; if (m0_out !== '0) begin failures++; $display("FAIL err_m0_zero: got %h exp 0", m0_out); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    m0_if.awaddr = 4'h4; m0_if.awvalid = 1; m0_if.wdata = 32'h1; m0_if.wstrb = 4'hf;
    m0_if.wvalid = 1; m0_if.bready = 1;
    s_if.awready = 1; s_if.wready = 1;
    step();
    step();
    m0_if.awvalid = 0; m0_if.wvalid = 0;
    #1;
    checks++; if ({dbg_state, busy} !== 4'b010_1) begin failures++; $display("FAIL rstm_in_wresp: got %b exp 0101", {dbg_state, busy}); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (all_out !== '0) begin failures++; $display("FAIL rstm_all_out: got %h exp 0", all_out); end
    clear_inputs();
    step();
    rst_n = 1'b1;
    step();
    m0_if.awaddr = 4'h0; m0_if.awvalid = 1; m0_if.wdata = 32'h5a; m0_if.wstrb = 4'hf;
    m0_if.wvalid = 1; m0_if.bready = 1;
    s_if.awready = 1; s_if.wready = 1;
    step();
    checks++; if ({grant, s_if.awaddr, s_if.wdata} !== {2'b01, 4'h0, 32'h5a}) begin
      failures++; $display("FAIL rstm_fresh_wr: got %b/%h/%h exp 01/0/5a", grant, s_if.awaddr, s_if.wdata); end
    step();
    m0_if.awvalid = 0; m0_if.wvalid = 0; s_if.bvalid = 1;
    #1;
    checks++; if ({m0_if.bvalid, m0_if.bresp} !== 3'b100) begin
      failures++; $display("FAIL rstm_fresh_b: got %b exp 100", {m0_if.bvalid, m0_if.bresp}); end
    step();
    s_if.bvalid = 0;
    #1;
    checks++; if ({grant, busy} !== 3'b000) begin failures++; $display("FAIL rstm_fresh_idle: got %b exp 000", {grant, busy}); end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_simul_reads();
    test_aw_before_w();
    test_write_over_read();
    test_slverr_read();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
